// File: rtl/mux_arbiter_if.sv
// Request/grant and result handshake bundle shared by the operand arbiter,
// its two producers and the downstream consumer.
interface mux_arbiter_if #(
    parameter int unsigned Width = 8
);
    logic             ReqA;
    logic [Width-1:0] NumA;
    logic             LockA;
    logic             GntA;
    logic             ReqB;
    logic [Width-1:0] NumB;
    logic             LockB;
    logic             GntB;
    logic             Select;
    logic [Width-1:0] Result;
    logic             OutValid;
    logic             OutReady;

    modport master (
        input  ReqA, NumA, LockA, ReqB, NumB, LockB, OutReady,
        output GntA, GntB, Select, Result, OutValid
    );

    modport slave (
        output ReqA, NumA, LockA, ReqB, NumB, LockB, OutReady,
        input  GntA, GntB, Select, Result, OutValid
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-requester arbiter for the 2:1 operand mux: picks the owner of the shared
// result path, drives the mux select and registers the chosen word downstream.
module mux_arbiter #(
    parameter int unsigned Width    = 8,
    parameter int unsigned MaxBurst = 4
) (
    input logic            Clk,
    input logic            Rst_n,
    mux_arbiter_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_a_q, last_a_d;
    logic [7:0]       burst_q, burst_d;
    logic             select_q, select_d;
    logic [Width-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;

    logic       room, gnt_a, gnt_b, acc_a, acc_b, accept;
    logic [7:0] burst_inc;
    logic       own_req, own_lock, other_req;
    logic [1:0] other_state;

    always_comb begin
        room      = ~out_valid_q | bus.OutReady;
        gnt_a     = (state_q == OWN_A) & room;
        gnt_b     = (state_q == OWN_B) & room;
        acc_a     = gnt_a & bus.ReqA;
        acc_b     = gnt_b & bus.ReqB;
        accept    = acc_a | acc_b;
        burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

        // Owner/other views let OWN_A and OWN_B share one set of rules
        own_req     = (state_q == OWN_B) ? bus.ReqB  : bus.ReqA;
        own_lock    = (state_q == OWN_B) ? bus.LockB : bus.LockA;
        other_req   = (state_q == OWN_B) ? bus.ReqA  : bus.ReqB;
        other_state = (state_q == OWN_B) ? OWN_A     : OWN_B;

        state_d     = state_q;
        last_a_d    = last_a_q;
        burst_d     = burst_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            result_d    = acc_b ? bus.NumB : bus.NumA;
            out_valid_d = 1'b1;
            last_a_d    = acc_a;
            burst_d     = burst_inc;
        end else if (out_valid_q && bus.OutReady) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.ReqA && bus.ReqB) state_d = last_a_q ? OWN_B : OWN_A;
                else if (bus.ReqA)        state_d = OWN_A;
                else if (bus.ReqB)        state_d = OWN_B;
            end
            OWN_A, OWN_B: begin
                if (accept) begin
                    if (other_req && (!own_lock || burst_inc == 8'(MaxBurst)))
                        state_d = other_state;
                    else if (!(own_req || own_lock))
                        state_d = IDLE;
                end else if (!own_req && !own_lock) begin
                    state_d = other_req ? other_state : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any ownership change restarts the burst count
        if (state_d != state_q) burst_d = '0;

        select_d = (state_d == OWN_B);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            last_a_q    <= 1'b0;
            burst_q     <= '0;
            select_q    <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_a_q    <= last_a_d;
            burst_q     <= burst_d;
            select_q    <= select_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.GntA     = gnt_a;
    assign bus.GntB     = gnt_b;
    assign bus.Select   = select_q;
    assign bus.Result   = result_q;
    assign bus.OutValid = out_valid_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized scoreboard bench for mux_arbiter against an ownership-level model.
module tb_mux_arbiter;
    localparam int MAXB = 4;

    logic Clk;
    logic Rst_n;

    mux_arbiter_if #(.Width(8)) bus ();

    mux_arbiter #(.Width(8), .MaxBurst(MAXB)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner is -1 (none), 0 (A) or 1 (B)
    int         m_owner = -1;
    bit         m_last_a = 1'b0;
    int         m_burst = 0;
    bit         m_valid = 1'b0;
    logic [7:0] m_result = 8'h00;
    logic [7:0] exp_q[$];

    always @(negedge Clk) begin : model
        bit         req[2];
        bit         lock[2];
        logic [7:0] num[2];
        bit         room, acc;
        int         x, o;
        if (!Rst_n) begin
            m_owner = -1; m_last_a = 1'b0; m_burst = 0;
            m_valid = 1'b0; m_result = 8'h00;
            exp_q.delete();
        end else begin
            req[0] = bus.ReqA;  req[1] = bus.ReqB;
            lock[0] = bus.LockA; lock[1] = bus.LockB;
            num[0] = bus.NumA;  num[1] = bus.NumB;
            room = !m_valid || bus.OutReady;

            check("GntA",     32'(bus.GntA),     32'(m_owner == 0 && room));
            check("GntB",     32'(bus.GntB),     32'(m_owner == 1 && room));
            check("Select",   32'(bus.Select),   32'(m_owner == 1));
            check("OutValid", 32'(bus.OutValid), 32'(m_valid));
            check("Result",   32'(bus.Result),   32'(m_result));

            acc = (m_owner >= 0) && room && req[m_owner];
            if (acc) begin
                exp_q.push_back(num[m_owner]);
                m_result = num[m_owner];
                m_valid  = 1'b1;
                m_last_a = (m_owner == 0);
                m_burst  = (m_burst >= 255) ? 255 : m_burst + 1;
            end else if (m_valid && bus.OutReady) begin
                m_valid = 1'b0;
            end

            if (m_owner < 0) begin
                if (req[0] && req[1]) m_owner = m_last_a ? 1 : 0;
                else if (req[0])      m_owner = 0;
                else if (req[1])      m_owner = 1;
                m_burst = 0;
            end else begin
                x = m_owner;
                o = 1 - x;
                if (acc) begin
                    if (req[o] && (!lock[x] || m_burst == MAXB)) begin
                        m_owner = o;
                        m_burst = 0;
                    end
                end else if (!req[x] && !lock[x]) begin
                    m_owner = req[o] ? o : -1;
                    m_burst = 0;
                end
            end
        end
    end

    // Monitor: each consumed word must be the oldest word the model accepted
    always @(negedge Clk) begin : monitor
        logic [7:0] e;
        if (Rst_n && bus.OutValid && bus.OutReady) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", 32'(bus.Result), 32'(e));
            end
        end
    end

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic quiet(input int n);
        bus.ReqA = 0; bus.ReqB = 0; bus.LockA = 0; bus.LockB = 0;
        bus.OutReady = 1;
        repeat (n) cycle();
    endtask

    initial begin
        bit acc_a, acc_b;
        Rst_n = 1'b0;
        bus.ReqA = 0; bus.ReqB = 0; bus.LockA = 0; bus.LockB = 0;
        bus.NumA = 8'h00; bus.NumB = 8'h00; bus.OutReady = 1'b0;
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;

        // Idle after reset
        repeat (10) cycle();

        // Single A word
        bus.ReqA = 1; bus.NumA = 8'h3C; bus.OutReady = 1;
        cycle();
        cycle();
        quiet(3);

        // Both requesting, no locks: strict alternation
        bus.ReqA = 1; bus.ReqB = 1; bus.NumA = 8'hA1; bus.NumB = 8'hB2;
        repeat (10) cycle();
        quiet(3);

        // A locked: burst of MaxBurst, then B gets one word, then A again
        bus.ReqA = 1; bus.ReqB = 1; bus.LockA = 1; bus.NumA = 8'h4A; bus.NumB = 8'h4B;
        repeat (14) cycle();
        quiet(3);

        // Backpressure on B
        bus.ReqB = 1; bus.NumB = 8'h55; bus.OutReady = 0;
        repeat (6) cycle();
        bus.OutReady = 1;
        repeat (4) cycle();
        quiet(3);

        // Asynchronous reset while B owns with a word pending
        bus.ReqB = 1; bus.NumB = 8'h66; bus.OutReady = 0;
        repeat (3) cycle();
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        bus.ReqB = 0;
        #1;
        check("rst_GntA",     32'(bus.GntA),     32'd0);
        check("rst_GntB",     32'(bus.GntB),     32'd0);
        check("rst_Select",   32'(bus.Select),   32'd0);
        check("rst_OutValid", 32'(bus.OutValid), 32'd0);
        check("rst_Result",   32'(bus.Result),   32'd0);
        @(posedge Clk);
        #2 Rst_n = 1'b1;
        cycle();
        bus.ReqA = 1; bus.ReqB = 1; bus.NumA = 8'h11; bus.NumB = 8'h22; bus.OutReady = 1;
        @(negedge Clk);
        @(negedge Clk);
        check("first_tie_GntA", 32'(bus.GntA), 32'd1);
        check("first_tie_GntB", 32'(bus.GntB), 32'd0);

        // Random traffic honouring hold-until-granted, with random withdrawals
        repeat (3000) begin
            @(negedge Clk);
            acc_a = bus.GntA && bus.ReqA;
            acc_b = bus.GntB && bus.ReqB;
            cycle();
            if (bus.ReqA && !acc_a) begin
                if ($urandom_range(15) == 0) bus.ReqA = 0;
            end else begin
                bus.ReqA = ($urandom_range(2) != 0);
                bus.NumA = 8'($urandom);
            end
            if (bus.ReqB && !acc_b) begin
                if ($urandom_range(15) == 0) bus.ReqB = 0;
            end else begin
                bus.ReqB = ($urandom_range(2) != 0);
                bus.NumB = 8'($urandom);
            end
            bus.LockA = ($urandom_range(3) == 0);
            bus.LockB = ($urandom_range(3) == 0);
            bus.OutReady = ($urandom_range(3) != 0);
        end
        quiet(6);
        @(negedge Clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester arbiter and output stage for the 8-bit 2:1 operand multiplexer. It decides which requester (A or B) owns the shared result path each cycle and drives the multiplexer select. It registers the chosen word and hands it downstream with a valid/ready handshake. It sits between the two operand producers and the single consumer of the multiplexed result.

## Interface
- Width, 8, data width of NumA, NumB and Result.
- MaxBurst, 4, maximum consecutive accepts from one owner while the other requester waits; legal range 1..255.

- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous and active-low.
- ReqA  input  1  requester A has a word on NumA.
- NumA  input  Width  requester A data.
- LockA  input  1  A asks to keep ownership after its current accept.
- GntA  output  1  A's word is taken this cycle when ReqA is also high.
- ReqB, NumB, LockB, GntB: same as the A ports, for requester B.
- Select  output  1  multiplexer select: 0 picks NumA, 1 picks NumB.
- Result  output  Width  registered output word.
- OutValid  output  1  Result holds an unconsumed word.
- OutReady  input  1  consumer takes Result when OutValid is also high.

## Operation
- States:
  - IDLE: no owner.
  - OWN_A: A owns the path.
  - OWN_B: B owns the path.
- State, Select, Result and OutValid are registers.
- Select = 1 only in OWN_B.
- Pointer LastA = 1 when A was the last requester accepted.
- BurstCnt is an 8-bit count of consecutive accepts by the current owner.
- Room = ~OutValid | OutReady.
- GntA = (state==OWN_A) & Room. GntB is the same for OWN_B. Both grants are combinational from registers and OutReady.
- AccA = GntA & ReqA; AccB likewise. At most one accept can happen per cycle.
- On any accept:
  - Result <= owner's Num.
  - OutValid <= 1.
  - LastA <= (owner==A).
  - BurstCnt <= BurstCnt+1, saturating at 255.
- When OutValid & OutReady with no accept: OutValid <= 0 and Result holds its value.
- IDLE transitions:
  - Both requesting: go to the owner opposite LastA.
  - One requesting: go to that requester's OWN state.
  - None requesting: stay in IDLE.
  - On every transition BurstCnt <= 0.
- OWN_x after an accept, first matching rule wins:
  - Other requester waiting, and either Lock_x=0 or the new BurstCnt = MaxBurst: go to OWN_other, BurstCnt <= 0.
  - Otherwise, if Req_x or Lock_x: stay in OWN_x.
  - Otherwise: go to IDLE.
- OWN_x without an accept:
  - Req_x=0 and Lock_x=0: go to OWN_other if the other requester is waiting, else IDLE. BurstCnt <= 0.
  - Req_x=1 and blocked only by Room=0: stay in OWN_x.
- Lock with no other requester pending never triggers a switch, whatever BurstCnt is.
- Switching ownership takes effect on the next cycle. In that cycle Select changes and the new owner's grant can assert.

## Timing
- Reset values: state IDLE, LastA 0 (A wins the first tie), BurstCnt 0, Select 0, Result 0, OutValid 0, GntA 0, GntB 0.
- Rst_n low mid-transfer clears everything immediately, including a pending OutValid. The pending word is lost by design.
- Latency from IDLE: request in cycle n, OWN state in n+1, accept in n+1 if Room, OutValid high in n+2.
- Throughput: one word per cycle while an owner keeps requesting and OutReady stays high.
- An owner switch costs no bubble: last accept by A in cycle n, first accept by B in n+1.
- Backpressure: while OutValid=1 and OutReady=0, Result, OutValid and the grants hold steady.
- OutValid and OutReady high in the same cycle as an accept: the new word replaces the old one and OutValid stays 1.
- Requesters must hold Req and Num stable until granted. Dropping Req before a grant is legal and is treated as a withdrawal.

## Test plan
- Reset release, no requests, 10 cycles -> Select=0, OutValid=0, Result=0x00, GntA=GntB=0 throughout.
- ReqA=1 with NumA=0x3C in cycle 0, OutReady=1 -> state OWN_A in cycle 1 with GntA=1; Result=0x3C and OutValid=1 in cycle 2; Select stays 0.
- ReqA and ReqB held high continuously, no locks, NumA=0xA1, NumB=0xB2, OutReady=1 -> Result alternates 0xA1, 0xB2, 0xA1, ... one word per cycle; Select toggles every cycle.
- LockA=1, ReqA=1 and ReqB=1 held, MaxBurst=4 -> exactly 4 A words, then B owns; with LockB=0 and ReqA still high, A regains ownership after one B word.
- OutReady=0 for 5 cycles with ReqB=1 and NumB=0x55 -> exactly one accept, Result holds 0x55, OutValid holds 1, GntB=0 while blocked; OutReady=1 resumes one word per cycle.
- Rst_n pulsed low while in OWN_B with OutValid=1 -> all outputs return to reset values asynchronously; after release with both requesting, A is granted first.
